// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: per-stage hold vector, flush/PC redirect on
// exceptions, multicycle EX timing and a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int MC_LEN_W = 6,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                ex_mc_start,
  input  logic [MC_LEN_W-1:0] ex_mc_len,
  input  logic                excep_valid,
  input  logic [31:0]         excep_pc,
  input  logic                stall_cnt_clr,
  output logic [5:0]          stall,
  output logic                flush,
  output logic                pc_load,
  output logic [31:0]         new_pc,
  output logic                mc_done,
  output logic                mc_busy,
  output logic [CNT_W-1:0]    stall_cnt
);

  typedef enum logic [1:0] {IDLE, MC_BUSY, FLUSH} state_e;

  localparam logic [5:0]          STALL_LU = 6'b000111;
  localparam logic [5:0]          STALL_MC = 6'b001111;
  localparam logic [MC_LEN_W-1:0] LEN_ONE  = MC_LEN_W'(1);

  state_e              state_q, state_d;
  logic [MC_LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]         new_pc_q, new_pc_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [MC_LEN_W-1:0] len_eff;
  logic [5:0]          stall_raw;
  logic                flush_raw, done_raw, busy_raw;

  // A zero-length op still occupies its start cycle.
  assign len_eff = (ex_mc_len == '0) ? LEN_ONE : ex_mc_len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      new_pc_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      new_pc_q    <= new_pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    new_pc_d = new_pc_q;
    case (state_q)
      IDLE: begin
        if (excep_valid) begin
          state_d  = FLUSH;
          new_pc_d = excep_pc;
        end else if (ex_mc_start && (len_eff > LEN_ONE)) begin
          state_d = MC_BUSY;
          cnt_d   = len_eff - LEN_ONE;
        end
      end
      MC_BUSY: begin
        if (excep_valid) begin
          state_d  = FLUSH;
          cnt_d    = '0;
          new_pc_d = excep_pc;
        end else if (cnt_q > LEN_ONE) begin
          cnt_d = cnt_q - LEN_ONE;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        if (excep_valid) begin
          new_pc_d = excep_pc;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_raw = '0;
    flush_raw = 1'b0;
    done_raw  = 1'b0;
    busy_raw  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!excep_valid) begin
          if (ex_mc_start && (len_eff > LEN_ONE)) begin
            stall_raw = STALL_MC;
          end else begin
            done_raw  = ex_mc_start;
            stall_raw = stallreq_id ? STALL_LU : 6'b000000;
          end
        end
      end
      MC_BUSY: begin
        busy_raw = 1'b1;
        if (!excep_valid) begin
          if (cnt_q > LEN_ONE) begin
            stall_raw = STALL_MC;
          end else begin
            done_raw  = 1'b1;
            stall_raw = stallreq_id ? STALL_LU : 6'b000000;
          end
        end
      end
      FLUSH: flush_raw = 1'b1;
      default: ;
    endcase
  end

  // Combinational outputs are forced quiet while reset is held.
  assign stall   = rst ? stall_raw : 6'b000000;
  assign flush   = rst & flush_raw;
  assign pc_load = rst & flush_raw;
  assign mc_done = rst & done_raw;
  assign mc_busy = rst & busy_raw;
  assign new_pc  = new_pc_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr) begin
      stall_cnt_d = '0;
    end else if (stall[0] && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl: timestamp-based reference model checked on
// every falling edge, plus directed scenarios with hand-computed expectations.
module tb_pipe_ctrl;

  localparam int MC_LEN_W = 6;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = 15;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                stallreq_id = 1'b0;
  logic                ex_mc_start = 1'b0;
  logic [MC_LEN_W-1:0] ex_mc_len = '0;
  logic                excep_valid = 1'b0;
  logic [31:0]         excep_pc = '0;
  logic                stall_cnt_clr = 1'b0;
  logic [5:0]          stall;
  logic                flush, pc_load, mc_done, mc_busy;
  logic [31:0]         new_pc;
  logic [CNT_W-1:0]    stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_ctrl #(.MC_LEN_W(MC_LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_start(ex_mc_start),
    .ex_mc_len(ex_mc_len), .excep_valid(excep_valid), .excep_pc(excep_pc),
    .stall_cnt_clr(stall_cnt_clr), .stall(stall), .flush(flush), .pc_load(pc_load),
    .new_pc(new_pc), .mc_done(mc_done), .mc_busy(mc_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: an op is described by the cycle number in which it completes.
  bit          m_flush_pend, m_mc_act;
  int          m_cyc, m_mc_end, m_cnt, m_len;
  logic [31:0] m_pc;
  logic [5:0]  e_stall;
  bit          e_flush, e_done, e_busy, n_flush;

  initial begin
    m_flush_pend = 0; m_mc_act = 0; m_cyc = 0; m_mc_end = 0; m_cnt = 0; m_pc = '0;
  end

  always @(negedge clk) begin
    e_stall = 6'b0; e_flush = 0; e_done = 0; e_busy = 0;
    if (!rst) begin
      m_flush_pend = 0; m_mc_act = 0; m_pc = '0; m_cnt = 0;
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_flush", 32'(flush), 32'h0);
      chk("rst_pc_load", 32'(pc_load), 32'h0);
      chk("rst_mc_done", 32'(mc_done), 32'h0);
      chk("rst_mc_busy", 32'(mc_busy), 32'h0);
      chk("rst_new_pc", new_pc, 32'h0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    end else begin
      n_flush = 0;
      if (m_flush_pend) begin
        e_flush = 1;
        if (excep_valid) begin n_flush = 1; end
      end else if (m_mc_act) begin
        e_busy = 1;
        if (excep_valid) begin
          n_flush = 1; m_mc_act = 0;
        end else if (m_cyc == m_mc_end) begin
          e_done = 1; m_mc_act = 0;
          e_stall = stallreq_id ? 6'd7 : 6'd0;
        end else begin
          e_stall = 6'd15;
        end
      end else begin
        if (excep_valid) begin
          n_flush = 1;
        end else if (ex_mc_start) begin
          m_len = (ex_mc_len == 0) ? 1 : int'(ex_mc_len);
          if (m_len == 1) begin
            e_done = 1;
            e_stall = stallreq_id ? 6'd7 : 6'd0;
          end else begin
            e_stall = 6'd15;
            m_mc_act = 1;
            m_mc_end = m_cyc + m_len - 1;
          end
        end else begin
          e_stall = stallreq_id ? 6'd7 : 6'd0;
        end
      end
      chk("stall", 32'(stall), 32'(e_stall));
      chk("flush", 32'(flush), 32'(e_flush));
      chk("pc_load", 32'(pc_load), 32'(e_flush));
      chk("mc_done", 32'(mc_done), 32'(e_done));
      chk("mc_busy", 32'(mc_busy), 32'(e_busy));
      chk("new_pc", new_pc, m_pc);
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      if (excep_valid && n_flush) m_pc = excep_pc;
      m_flush_pend = n_flush;
      if (stall_cnt_clr) m_cnt = 0;
      else if (e_stall[0] && m_cnt < CNT_MAX) m_cnt++;
    end
    m_cyc++;
  end

  task automatic drive(input bit r, input bit ld, input bit st, input int len,
                       input bit ex, input logic [31:0] pc, input bit clr);
    @(posedge clk);
    #1;
    rst = r; stallreq_id = ld; ex_mc_start = st; ex_mc_len = MC_LEN_W'(len);
    excep_valid = ex; excep_pc = pc; stall_cnt_clr = clr;
  endtask

  task automatic idle_cycle();
    drive(1, 0, 0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'($urandom), 1'($urandom), int'($urandom_range(0, 63)), 1'($urandom),
            $urandom, 1'($urandom));
      @(negedge clk);
      chk("lit_rst_stall", 32'(stall), 32'h0);
      chk("lit_rst_new_pc", new_pc, 32'h0);
      chk("lit_rst_stall_cnt", 32'(stall_cnt), 32'h0);
    end
    idle_cycle();
    @(negedge clk);
    chk("lit_post_rst_flush", 32'(flush), 32'h0);

    // Load-use for two cycles.
    drive(1, 1, 0, 0, 0, 32'h0, 0);
    @(negedge clk); chk("lit_lu_stall1", 32'(stall), 32'h07);
    drive(1, 1, 0, 0, 0, 32'h0, 0);
    @(negedge clk); chk("lit_lu_stall2", 32'(stall), 32'h07);
    idle_cycle();
    @(negedge clk);
    chk("lit_lu_stall_off", 32'(stall), 32'h0);
    chk("lit_lu_cnt", 32'(stall_cnt), 32'd2);

    // Divide of length 5.
    drive(1, 0, 1, 5, 0, 32'h0, 0);
    @(negedge clk);
    chk("lit_div_c1_stall", 32'(stall), 32'h0f);
    chk("lit_div_c1_busy", 32'(mc_busy), 32'h0);
    for (int c = 2; c <= 4; c++) begin
      idle_cycle();
      @(negedge clk);
      chk("lit_div_mid_stall", 32'(stall), 32'h0f);
      chk("lit_div_mid_busy", 32'(mc_busy), 32'h1);
      chk("lit_div_mid_done", 32'(mc_done), 32'h0);
    end
    idle_cycle();
    @(negedge clk);
    chk("lit_div_c5_done", 32'(mc_done), 32'h1);
    chk("lit_div_c5_stall", 32'(stall), 32'h0);
    chk("lit_div_c5_busy", 32'(mc_busy), 32'h1);
    idle_cycle();
    @(negedge clk);
    chk("lit_div_after_busy", 32'(mc_busy), 32'h0);
    chk("lit_div_cnt", 32'(stall_cnt), 32'd6);

    // Single-cycle ops, lengths 1 and 0.
    for (int k = 1; k >= 0; k--) begin
      drive(1, 0, 1, k, 0, 32'h0, 0);
      @(negedge clk);
      chk("lit_single_done", 32'(mc_done), 32'h1);
      chk("lit_single_stall", 32'(stall), 32'h0);
      idle_cycle();
      @(negedge clk);
      chk("lit_single_idle_busy", 32'(mc_busy), 32'h0);
      chk("lit_single_idle_done", 32'(mc_done), 32'h0);
    end

    // Exception aborts a length-8 op in its third cycle.
    drive(1, 0, 1, 8, 0, 32'h0, 0);
    idle_cycle();
    drive(1, 0, 0, 0, 1, 32'h0000_0120, 0);
    @(negedge clk);
    chk("lit_abort_stall", 32'(stall), 32'h0);
    chk("lit_abort_done", 32'(mc_done), 32'h0);
    idle_cycle();
    @(negedge clk);
    chk("lit_abort_flush", 32'(flush), 32'h1);
    chk("lit_abort_pc_load", 32'(pc_load), 32'h1);
    chk("lit_abort_new_pc", new_pc, 32'h0000_0120);
    chk("lit_abort_fl_stall", 32'(stall), 32'h0);
    chk("lit_abort_fl_done", 32'(mc_done), 32'h0);
    for (int c = 0; c < 8; c++) begin
      idle_cycle();
      @(negedge clk);
      chk("lit_abort_no_done", 32'(mc_done), 32'h0);
      chk("lit_abort_idle_flush", 32'(flush), 32'h0);
    end

    // Saturation then clear racing an increment.
    drive(1, 0, 0, 0, 0, 32'h0, 1);
    for (int c = 0; c < 20; c++) drive(1, 1, 0, 0, 0, 32'h0, 0);
    drive(1, 1, 0, 0, 0, 32'h0, 1);
    @(negedge clk);
    chk("lit_sat_cnt", 32'(stall_cnt), 32'd15);
    idle_cycle();
    @(negedge clk);
    chk("lit_clr_cnt", 32'(stall_cnt), 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      drive($urandom_range(0, 149) != 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 6) == 0,
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 9)),
            $urandom_range(0, 19) == 0,
            $urandom,
            $urandom_range(0, 39) == 0);
    end
    idle_cycle();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
